sha3_theta: RTL and testbench

SHA3_THETA -- requirements
Module: sha3_theta

---
 rtl/sha3_pkg.sv | 30 +++
 rtl/sha3_col_parity.sv | 21 ++
 rtl/sha3_theta.sv | 130 +++++++++++++
 tb/tb_sha3_theta.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// -----------------------------------------------------------------------------
// sha3_pkg
//   Definitions shared by the Keccak-f[1600] step blocks (sha3_theta,
//   sha3_rho, ...).
//   LANE_W : lane width in bits (64 for Keccak-f[1600])
//   NLANE  : lanes per row and rows per state (5)
//   lane_t : one 64-bit lane; bit 0 is the LSB
//   row_t  : one row of five lanes, element [x] is lane A[x][y]
//   rotl() : rotate a lane left by 'amount' bit positions
// -----------------------------------------------------------------------------
package sha3_pkg;

    localparam int LANE_W = 64;
    localparam int NLANE  = 5;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t row_t [NLANE];

    // Rotation with wrap-around: bits shifted out at the top come back in at
    // bit 0. An amount of 0 (or a multiple of LANE_W) returns the lane as is.
    function automatic lane_t rotl(input lane_t v, input int unsigned amount);
        int unsigned a;
        a = amount % unsigned'(LANE_W);
        if (a == 0) begin
            return v;
        end
        return (v << a) | (v >> (unsigned'(LANE_W) - a));
    endfunction

endpackage

// File: rtl/sha3_col_parity.sv
// -----------------------------------------------------------------------------
// sha3_col_parity
//   Combinational parity of one state column: the XOR of the five lanes
//   A[x][0..4] that share the same x.
//   a0_i..a4_i : lanes A[x][0] .. A[x][4]
//   par_o      : C[x] = a0_i ^ a1_i ^ a2_i ^ a3_i ^ a4_i
// -----------------------------------------------------------------------------
module sha3_col_parity
    import sha3_pkg::*;
(
    input  lane_t a0_i,
    input  lane_t a1_i,
    input  lane_t a2_i,
    input  lane_t a3_i,
    input  lane_t a4_i,
    output lane_t par_o
);

    assign par_o = a0_i ^ a1_i ^ a2_i ^ a3_i ^ a4_i;

endmodule

// File: rtl/sha3_theta.sv
// -----------------------------------------------------------------------------
// sha3_theta
//   Keccak-f[1600] theta step as a two-stage pipeline with no backpressure.
//   Stage 1 captures the state and its five column parities C[x]; stage 2
//   forms D[x] = C[x-1] ^ ROTL1(C[x+1]) and registers A'[x][y] = A[x][y]^D[x].
//   clk           : sole clock, rising edge
//   rst           : asynchronous, active-high reset
//   isa..ise      : input rows y=0..4, element [x] is lane A[x][y]
//   sample        : input state valid this cycle (accepted every cycle)
//   osa..ose      : theta result rows y=0..4, same indexing as inputs
//   good          : one-cycle pulse per new result; outputs hold otherwise
// -----------------------------------------------------------------------------
module sha3_theta
    import sha3_pkg::*;
#(
    parameter int LANE_W = 64,
    parameter int NLANE  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LANE_W-1:0] isa [NLANE],
    input  logic [LANE_W-1:0] isb [NLANE],
    input  logic [LANE_W-1:0] isc [NLANE],
    input  logic [LANE_W-1:0] isd [NLANE],
    input  logic [LANE_W-1:0] ise [NLANE],
    input  logic              sample,
    output logic [LANE_W-1:0] osa [NLANE],
    output logic [LANE_W-1:0] osb [NLANE],
    output logic [LANE_W-1:0] osc [NLANE],
    output logic [LANE_W-1:0] osd [NLANE],
    output logic [LANE_W-1:0] ose [NLANE],
    output logic              good
);

    // Input state gathered as [y][x] so both stages can loop over it.
    lane_t in_w  [NLANE][NLANE];
    lane_t par_w [NLANE];

    // Stage 1: registered state, column parities and valid.
    lane_t a_q   [NLANE][NLANE];
    lane_t c_q   [NLANE];
    logic  v1_q;

    // Stage 2: theta result and valid.
    lane_t d_w   [NLANE];
    lane_t o_d   [NLANE][NLANE];
    lane_t o_q   [NLANE][NLANE];
    logic  v2_q;

    always_comb begin
        for (int x = 0; x < NLANE; x++) begin
            in_w[0][x] = isa[x];
            in_w[1][x] = isb[x];
            in_w[2][x] = isc[x];
            in_w[3][x] = isd[x];
            in_w[4][x] = ise[x];
        end
    end

    for (genvar gx = 0; gx < NLANE; gx++) begin : g_col
        sha3_col_parity u_col_parity (
            .a0_i  (isa[gx]),
            .a1_i  (isb[gx]),
            .a2_i  (isc[gx]),
            .a3_i  (isd[gx]),
            .a4_i  (ise[gx]),
            .par_o (par_w[gx])
        );
    end

    // D[x] uses the left neighbour column as is and the right neighbour
    // rotated by one, so bit 63 of C[x+1] wraps into bit 0 of D[x].
    always_comb begin
        for (int x = 0; x < NLANE; x++) begin
            d_w[x] = c_q[(x + NLANE - 1) % NLANE] ^ rotl(c_q[(x + 1) % NLANE], 1);
        end
        for (int y = 0; y < NLANE; y++) begin
            for (int x = 0; x < NLANE; x++) begin
                o_d[y][x] = a_q[y][x] ^ d_w[x];
            end
        end
    end

    // Data registers load only behind their valid, so idle-cycle input data
    // never reaches the outputs and the last result holds while good=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int y = 0; y < NLANE; y++) begin
                c_q[y] <= '0;
                for (int x = 0; x < NLANE; x++) begin
                    a_q[y][x] <= '0;
                    o_q[y][x] <= '0;
                end
            end
        end else begin
            v1_q <= sample;
            v2_q <= v1_q;
            if (sample) begin
                for (int y = 0; y < NLANE; y++) begin
                    c_q[y] <= par_w[y];
                    for (int x = 0; x < NLANE; x++) begin
                        a_q[y][x] <= in_w[y][x];
                    end
                end
            end
            if (v1_q) begin
                for (int y = 0; y < NLANE; y++) begin
                    for (int x = 0; x < NLANE; x++) begin
                        o_q[y][x] <= o_d[y][x];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int x = 0; x < NLANE; x++) begin
            osa[x] = o_q[0][x];
            osb[x] = o_q[1][x];
            osc[x] = o_q[2][x];
            osd[x] = o_q[3][x];
            ose[x] = o_q[4][x];
        end
    end

    assign good = v2_q;

endmodule

// File: tb/tb_sha3_theta.sv
// -----------------------------------------------------------------------------
// tb_sha3_theta
//   Bench for sha3_theta. Stimulus pushes the expected theta result into a
//   queue; an independent monitor pops and compares on every good pulse and
//   checks that outputs hold (or read zero in reset) otherwise. The reference
//   model works bit by bit from the column-parity definition of theta on a
//   flat 1600-bit state, bit index (y*5+x)*64+z.
// -----------------------------------------------------------------------------
module tb_sha3_theta;
    import sha3_pkg::*;

    localparam int SW = 1600;

    logic clk = 1'b0;
    logic rst;
    logic sample;
    row_t isa, isb, isc, isd, ise;
    row_t osa, osb, osc, osd, ose;
    logic good;

    logic [SW-1:0] exp_q[$];
    int            stamp_q[$];
    logic [SW-1:0] last_exp = '0;
    logic [SW-1:0] out_flat;
    int            cyc      = 0;
    int            checks   = 0;
    int            failures = 0;

    sha3_theta dut (
        .clk    (clk),
        .rst    (rst),
        .isa    (isa),
        .isb    (isb),
        .isc    (isc),
        .isd    (isd),
        .ise    (ise),
        .sample (sample),
        .osa    (osa),
        .osb    (osb),
        .osc    (osc),
        .osd    (osd),
        .ose    (ose),
        .good   (good)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        out_flat = '0;
        for (int x = 0; x < 5; x++) begin
            out_flat[(0*5+x)*64 +: 64] = osa[x];
            out_flat[(1*5+x)*64 +: 64] = osb[x];
            out_flat[(2*5+x)*64 +: 64] = osc[x];
            out_flat[(3*5+x)*64 +: 64] = osd[x];
            out_flat[(4*5+x)*64 +: 64] = ose[x];
        end
    end

    // ---------------- reference model ----------------
    // Bit (x,y,z) of the result is the input bit XOR the parity of column
    // x-1 at the same z XOR the parity of column x+1 at z-1 (mod 64).
    function automatic logic [SW-1:0] theta_ref(input logic [SW-1:0] a);
        logic [SW-1:0] r;
        logic          par [5][64];
        for (int x = 0; x < 5; x++) begin
            for (int z = 0; z < 64; z++) begin
                par[x][z] = 1'b0;
                for (int y = 0; y < 5; y++) begin
                    par[x][z] = par[x][z] ^ a[(y*5+x)*64+z];
                end
            end
        end
        r = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                for (int z = 0; z < 64; z++) begin
                    r[(y*5+x)*64+z] = a[(y*5+x)*64+z] ^ par[(x+4)%5][z]
                                      ^ par[(x+1)%5][(z+63)%64];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] s;
        for (int i = 0; i < SW/32; i++) begin
            s[i*32 +: 32] = $urandom();
        end
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input logic [SW-1:0] st);
        for (int x = 0; x < 5; x++) begin
            isa[x] = st[(0*5+x)*64 +: 64];
            isb[x] = st[(1*5+x)*64 +: 64];
            isc[x] = st[(2*5+x)*64 +: 64];
            isd[x] = st[(3*5+x)*64 +: 64];
            ise[x] = st[(4*5+x)*64 +: 64];
        end
    endtask

    // Present one state for one edge; the result is due two edges later.
    task automatic drive(input logic [SW-1:0] st);
        set_inputs(st);
        sample = 1'b1;
        exp_q.push_back(theta_ref(st));
        stamp_q.push_back(cyc + 2);
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with random data on the inputs.
    task automatic idle(input int n);
        repeat (n) begin
            set_inputs(rand_state());
            sample = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic report_diff(input string name, input logic [SW-1:0] got,
                               input logic [SW-1:0] want);
        for (int i = 0; i < 25; i++) begin
            if (got[i*64 +: 64] !== want[i*64 +: 64]) begin
                $display("FAIL %s: lane x=%0d y=%0d got %h expected %h (t=%0t)",
                         name, i % 5, i / 5, got[i*64 +: 64], want[i*64 +: 64], $time);
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        logic [SW-1:0] e;
        int            st;
        if (rst) begin
            checks++;
            if (good !== 1'b0 || out_flat !== '0) begin
                failures++;
                $display("FAIL reset_state: good=%b got nonzero=%b expected good=0 outputs=0",
                         good, |out_flat);
            end
            last_exp = '0;
        end else if (good) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_good: good=1 at cycle %0d with no result pending", cyc);
            end else begin
                e  = exp_q.pop_front();
                st = stamp_q.pop_front();
                if (out_flat !== e) begin
                    failures++;
                    report_diff("result", out_flat, e);
                end
                checks++;
                if (cyc != st) begin
                    failures++;
                    $display("FAIL latency: good at cycle %0d expected cycle %0d", cyc, st);
                end
                last_exp = e;
            end
        end else begin
            checks++;
            if (out_flat !== last_exp) begin
                failures++;
                report_diff("hold", out_flat, last_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [SW-1:0] s_one;
        logic [SW-1:0] s_msb;
        logic [SW-1:0] s_ones;
        s_one  = '0;
        s_one[0] = 1'b1;
        s_msb  = '0;
        s_msb[63] = 1'b1;
        s_ones = '1;

        rst    = 1'b1;
        sample = 1'b0;
        set_inputs('0);
        repeat (3) @(posedge clk);
        #1;

        // Release reset and sample on the very first edge afterwards.
        rst = 1'b0;
        drive('0);
        idle(3);

        // Single set bit, then its wrap-around twin, then all ones.
        drive(s_one);
        idle(3);
        drive(s_msb);
        idle(3);
        drive(s_ones);
        idle(3);

        // Back-to-back stream, then hold with random idle inputs.
        drive('0);
        drive(s_one);
        drive(s_ones);
        idle(6);

        // Reset one cycle after a sample: that state must never appear.
        drive(rand_state());
        rst    = 1'b1;
        sample = 1'b0;
        exp_q.delete();
        stamp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        drive(rand_state());
        idle(3);

        // Samples presented while reset is held are ignored.
        rst = 1'b1;
        exp_q.delete();
        stamp_q.delete();
        set_inputs(rand_state());
        sample = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sample = 1'b0;
        rst    = 1'b0;
        idle(3);

        // Random traffic with random gaps.
        repeat (300) begin
            if ($urandom_range(0, 2) != 0) begin
                drive(rand_state());
            end else begin
                idle($urandom_range(1, 3));
            end
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            idle(1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
